// File: rtl/dot4x_phase_gen.sv
// Lock qualification, synchronous reset generation and the 32-phase dot/phi
// timing counter for the clk_dot4x domain.
module dot4x_phase_gen #(
  parameter int LOCK_HOLD_CYCLES = 1024,
  parameter int HOLD_CNT_W       = 16
) (
  input  logic       clk_dot4x,
  input  logic       reset_n,
  input  logic       locked,
  output logic       rst_out,
  output logic [4:0] phase,
  output logic [2:0] dot_count,
  output logic       dot_rising,
  output logic       clk_phi,
  output logic       phi_rising,
  output logic       phi_falling,
  output logic       lock_lost
);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(LOCK_HOLD_CYCLES - 1);

  logic                  locked_meta_q;
  logic                  locked_s_q;
  state_t                state_q,     state_d;
  logic [HOLD_CNT_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic [4:0]            phase_q,     phase_d;
  logic                  lock_lost_q, lock_lost_d;
  logic                  in_run;

  // locked is asynchronous to clk_dot4x; two flops before anything looks at it.
  always_ff @(posedge clk_dot4x or negedge reset_n) begin
    if (!reset_n) begin
      locked_meta_q <= 1'b0;
      locked_s_q    <= 1'b0;
    end else begin
      locked_meta_q <= locked;
      locked_s_q    <= locked_meta_q;
    end
  end

  always_ff @(posedge clk_dot4x or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WAIT_LOCK;
      hold_cnt_q  <= '0;
      phase_q     <= 5'd0;
      lock_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      phase_q     <= phase_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    phase_d     = phase_q;
    lock_lost_d = lock_lost_q;
    case (state_q)
      WAIT_LOCK: begin
        phase_d = 5'd0;
        if (locked_s_q) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      HOLD: begin
        phase_d = 5'd0;
        if (!locked_s_q) begin
          state_d    = WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!locked_s_q) begin
          state_d     = WAIT_LOCK;
          phase_d     = 5'd0;
          lock_lost_d = 1'b1;
        end else begin
          // 5-bit counter wraps 31 -> 0 without a gap.
          phase_d = phase_q + 5'd1;
        end
      end
      default: begin
        state_d    = WAIT_LOCK;
        hold_cnt_d = '0;
        phase_d    = 5'd0;
      end
    endcase
  end

  // All outputs decode from registered state only; locked never reaches them combinationally.
  assign in_run      = (state_q == RUN);
  assign rst_out     = !in_run;
  assign phase       = in_run ? phase_q : 5'd0;
  assign dot_count   = in_run ? phase_q[4:2] : 3'd0;
  assign dot_rising  = in_run && (phase_q[1:0] == 2'd0);
  assign clk_phi     = in_run && phase_q[4];
  assign phi_rising  = in_run && (phase_q == 5'd16);
  assign phi_falling = in_run && (phase_q == 5'd0);
  assign lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_dot4x_phase_gen.sv
// Scoreboard bench for dot4x_phase_gen: stimulus queues expected outputs keyed
// by clock edge number, a negedge monitor pops and compares them.
module tb_dot4x_phase_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n0, locked0, reset_n1, locked1;
  logic       rst_out0, dot_rising0, clk_phi0, phi_rising0, phi_falling0, lock_lost0;
  logic [4:0] phase0;
  logic [2:0] dot_count0;
  logic       rst_out1, dot_rising1, clk_phi1, phi_rising1, phi_falling1, lock_lost1;
  logic [4:0] phase1;
  logic [2:0] dot_count1;

  dot4x_phase_gen #(.LOCK_HOLD_CYCLES(8), .HOLD_CNT_W(16)) dut (
    .clk_dot4x(clk), .reset_n(reset_n0), .locked(locked0),
    .rst_out(rst_out0), .phase(phase0), .dot_count(dot_count0),
    .dot_rising(dot_rising0), .clk_phi(clk_phi0), .phi_rising(phi_rising0),
    .phi_falling(phi_falling0), .lock_lost(lock_lost0)
  );

  dot4x_phase_gen #(.LOCK_HOLD_CYCLES(1), .HOLD_CNT_W(16)) dut1 (
    .clk_dot4x(clk), .reset_n(reset_n1), .locked(locked1),
    .rst_out(rst_out1), .phase(phase1), .dot_count(dot_count1),
    .dot_rising(dot_rising1), .clk_phi(clk_phi1), .phi_rising(phi_rising1),
    .phi_falling(phi_falling1), .lock_lost(lock_lost1)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          target;
    bit          which;
    logic [13:0] v;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  // Vector layout: {rst_out, phase[4:0], dot_count[2:0], dot_rising, clk_phi, phi_rising, phi_falling, lock_lost}
  function automatic logic [13:0] obs(bit which);
    if (which)
      return {rst_out1, phase1, dot_count1, dot_rising1, clk_phi1, phi_rising1, phi_falling1, lock_lost1};
    return {rst_out0, phase0, dot_count0, dot_rising0, clk_phi0, phi_rising0, phi_falling0, lock_lost0};
  endfunction

  function automatic logic [13:0] exp_rst(bit ll);
    return {1'b1, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, ll};
  endfunction

  function automatic logic [13:0] exp_run(int p, bit ll);
    logic [4:0] ph;
    ph = 5'(p % 32);
    return {1'b0, ph, ph[4:2], (ph[1:0] == 2'd0), ph[4], (ph == 5'd16), (ph == 5'd0), ll};
  endfunction

  task automatic check(string name, bit which, logic [13:0] want);
    logic [13:0] got;
    got = obs(which);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d edge %0d: got %b required %b (rst,phase,dot,dr,phi,pr,pf,ll)",
               name, which, edge_n, got, want);
    end
  endtask

  task automatic push(int target, bit which, logic [13:0] v, string name);
    exp_t e;
    e.target = target;
    e.which  = which;
    e.v      = v;
    e.name   = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(int t);
    while (edge_n < t) @(negedge clk);
  endtask

  // Monitor: compare every queued expectation whose edge has just occurred.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].target <= edge_n) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.target < edge_n) begin
        checks++;
        errors++;
        $display("FAIL %s stale entry for edge %0d at edge %0d", e.name, e.target, edge_n);
      end else begin
        check(e.name, e.which, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, b, c, k;
    reset_n0 = 1'b0; locked0 = 1'b0;
    reset_n1 = 1'b0; locked1 = 1'b0;
    repeat (3) @(negedge clk);
    check("por_reset", 1'b0, exp_rst(1'b0));
    check("por_reset1", 1'b1, exp_rst(1'b0));

    // Release reset with locked high: HOLD at edge 3, RUN at edge 11, then two phi cycles.
    base = edge_n;
    reset_n0 = 1'b1;
    locked0  = 1'b1;
    for (int e = 1; e <= 10; e++) push(base + e, 1'b0, exp_rst(1'b0), "t1_prerun");
    for (int e = 11; e <= 96; e++) push(base + e, 1'b0, exp_run(e - 11, 1'b0), "t2_run");
    push(base + 97, 1'b0, exp_rst(1'b1), "t4_drop");
    push(base + 98, 1'b0, exp_rst(1'b1), "t4_after_drop");

    // locked first sampled low at edge base+95, where phase is 20.
    wait_until(base + 94);
    locked0 = 1'b0;
    k = base + 95;
    wait_until(k + 3);

    // Relock with a one-cycle drop seen while hold_cnt == 5.
    locked0 = 1'b1;
    b = edge_n;
    for (int e = 1; e <= 17; e++) push(b + e, 1'b0, exp_rst(1'b1), "t3_hold");
    for (int e = 18; e <= 30; e++) push(b + e, 1'b0, exp_run(e - 18, 1'b1), "t5_relock");
    wait_until(b + 6);
    locked0 = 1'b0;
    wait_until(b + 7);
    locked0 = 1'b1;

    // Async reset mid-RUN takes effect without a clock edge.
    wait_until(b + 30);
    reset_n0 = 1'b0;
    #1;
    check("t5_async_reset", 1'b0, exp_rst(1'b0));
    push(b + 31, 1'b0, exp_rst(1'b0), "t5_in_reset");
    push(b + 32, 1'b0, exp_rst(1'b0), "t5_in_reset");
    wait_until(b + 32);

    // LOCK_HOLD_CYCLES=1: HOLD at edge 3, RUN at edge 4.
    c = edge_n;
    reset_n1 = 1'b1;
    locked1  = 1'b1;
    for (int e = 1; e <= 3; e++) push(c + e, 1'b1, exp_rst(1'b0), "t6_prerun");
    for (int e = 4; e <= 8; e++) push(c + e, 1'b1, exp_run(e - 4, 1'b0), "t6_run");
    wait_until(c + 9);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dot4x_phase_gen.md
Name: dot4x_phase_gen

Overview:
- Sits directly downstream of the NTSC dot4x clock generator.
- Consumes clk_dot4x (14.318181 MHz / 14 * 32 ≈ 32.727 MHz) and the MMCM locked flag.
- Qualifies lock and produces a synchronous reset for the video/bus core.
- Runs the 32-phase counter that yields the dot clock enable (every 4 clk_dot4x cycles, ≈ 8.18 MHz) and clk_phi (÷32, ≈ 1.0227 MHz) with edge strobes.

Parameters:
- LOCK_HOLD_CYCLES, 1024: consecutive synchronized-locked cycles required before leaving reset; legal range 1..65535.
- HOLD_CNT_W, 16: width of the hold counter; must satisfy 2^HOLD_CNT_W >= LOCK_HOLD_CYCLES.

Ports:
- clk_dot4x  in  1  sole clock, 4x dot clock from the clock generator.
- reset_n  in  1  asynchronous, active-low reset; clears every register.
- locked  in  1  MMCM lock flag, asynchronous to clk_dot4x.
- rst_out  out  1  synchronous active-high reset for downstream logic.
- phase  out  5  dot4x phase within the phi cycle, 0..31.
- dot_count  out  3  dot index within the phi cycle (phase[4:2]).
- dot_rising  out  1  dot clock enable.
- clk_phi  out  1  phi clock level.
- phi_rising  out  1  one-cycle strobe at the phi rising edge.
- phi_falling  out  1  one-cycle strobe at the phi falling edge.
- lock_lost  out  1  sticky flag: lock dropped after RUN was reached.

Behaviour:
- Reset (reset_n low, async):
  - sync FFs = 0, state = WAIT_LOCK, hold_cnt = 0, phase = 0, lock_lost = 0.
  - Outputs: rst_out = 1, dot_rising = phi_rising = phi_falling = clk_phi = 0, dot_count = 0.
- Reset release: deassertion is taken on a clk_dot4x edge; no internal reset synchronizer is required beyond the async clear.
- Lock synchronization:
  - locked passes through 2 FFs to give locked_s.
  - A locked level sampled at edge k appears on locked_s after edge k+1.
  - The FSM acts on it at edge k+2.
- FSM (all registered, one transition per edge):
  - WAIT_LOCK:
    - locked_s=1 -> HOLD, hold_cnt=0.
  - HOLD:
    - locked_s=0 -> WAIT_LOCK, hold_cnt=0.
    - Else if hold_cnt==LOCK_HOLD_CYCLES-1 -> RUN, phase=0.
    - Else hold_cnt+1.
  - RUN:
    - locked_s=0 -> WAIT_LOCK, phase=0, lock_lost=1.
    - Else phase = phase+1 mod 32; 31 wraps to 0 with no gap.
- Outputs (registered or decoded from registered state/phase only; no combinational path from locked):
  - rst_out = (state != RUN).
  - phase and dot_count are forced to 0 outside RUN.
  - In RUN only:
    - dot_rising = (phase[1:0]==0), i.e. 8 pulses per phi cycle, at phase 0,4,...,28.
    - clk_phi = phase[4]: low for phase 0..15, high for 16..31.
    - phi_rising = (phase==16).
    - phi_falling = (phase==0).
  - All strobes are 0 outside RUN.
- First RUN cycle: phase=0, rst_out=0, dot_rising=1, phi_falling=1. The downstream core treats this as the start of phi-low.
- Lock-loss details:
  - Loss mid-HOLD restarts qualification from 0.
  - Loss in RUN asserts rst_out on the same edge the state leaves RUN, truncating the phi cycle wherever it is.
  - lock_lost remains 1 across relock and is cleared only by reset_n.
- Glitch rejection: a locked pulse shorter than 1 clock may be missed; a 1-cycle drop seen on locked_s in HOLD or RUN must be acted on.
- LOCK_HOLD_CYCLES=1: HOLD lasts exactly one edge.
- Relock after loss: the full WAIT_LOCK -> HOLD -> RUN sequence is required; phase always restarts at 0.

Test Plan:
1. LOCK_HOLD_CYCLES=8; reset_n low then high, locked=1 sampled at edge 1 -> HOLD at edge 3; rst_out falls at edge 11 with phase=0, dot_rising=1, phi_falling=1.
2. In RUN, observe 64 cycles -> phase 0..31 twice; dot_rising at phases 0,4,...,28 (8 per cycle); clk_phi low 16 cycles, high 16; phi_rising only at phase 16, phi_falling only at phase 0.
3. LOCK_HOLD_CYCLES=8; drop locked for 1 cycle when hold_cnt=5 -> return to WAIT_LOCK, hold_cnt cleared; rst_out stays 1 until a fresh 8-cycle hold completes.
4. In RUN at phase 20, drop locked (sampled edge k) -> at edge k+2: rst_out=1, phase=0, clk_phi=0, all strobes 0, lock_lost=1.
5. Reassert locked -> RUN re-entered after 2+8 edges with phase=0; lock_lost still 1; assert reset_n low mid-RUN -> all outputs immediately at reset values, lock_lost=0.
6. LOCK_HOLD_CYCLES=1 -> rst_out falls exactly one edge after entering HOLD.
